// File: rtl/thread_issue_arbiter.sv
// thread_issue_arbiter
// Round-robin issue arbiter for NTHREAD requesting threads feeding a LAT-deep
// memory pipeline. One operation is granted per cycle. The granted operation
// is presented on registered iss_* outputs the following cycle, and a count of
// operations still in the pipeline is maintained.
//
// Optional feature: define THREAD_ISSUE_HAZARD_CHECK_EN to build the per-thread
// read/write-after-write hazard scoreboard. Without it no address comparators
// exist and every valid thread is eligible unless hold or rst is asserted.
module thread_issue_arbiter #(
    parameter int NTHREAD = 4,
    parameter int LAT     = 69,
    parameter int AW      = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NTHREAD-1:0]         req_valid,
    input  logic [NTHREAD*AW-1:0]      req_raddr0,
    input  logic [NTHREAD*AW-1:0]      req_raddr1,
    input  logic [NTHREAD*AW-1:0]      req_waddr,
    input  logic [NTHREAD-1:0]         req_we,
    input  logic                       hold,
    output logic [NTHREAD-1:0]         req_ready,
    output logic                       iss_valid,
    output logic [$clog2(NTHREAD)-1:0] iss_thread,
    output logic [AW-1:0]              iss_raddr0,
    output logic [AW-1:0]              iss_raddr1,
    output logic [AW-1:0]              iss_waddr,
    output logic                       iss_we,
    output logic [$clog2(LAT+1)-1:0]   inflight,
    output logic                       drained
);

    localparam int TW = $clog2(NTHREAD);
    localparam int IW = $clog2(LAT+1);

    // Arbitration state
    logic [TW-1:0]      ptr_reg;
    logic [NTHREAD-1:0] hazard;
    logic [NTHREAD-1:0] eligible;
    logic               grant_any;
    logic [TW-1:0]      grant_idx;
    logic [TW-1:0]      cand;

    // Fields of the granted thread
    logic [AW-1:0]      sel_raddr0;
    logic [AW-1:0]      sel_raddr1;
    logic [AW-1:0]      sel_waddr;
    logic               sel_we;

    // Issue registers
    logic               iss_valid_reg;
    logic [TW-1:0]      iss_thread_reg;
    logic [AW-1:0]      iss_raddr0_reg;
    logic [AW-1:0]      iss_raddr1_reg;
    logic [AW-1:0]      iss_waddr_reg;
    logic               iss_we_reg;

    // Occupancy tracking: busy_reg[i] set means an operation was granted i+1
    // cycles ago; the last stage marks the retirement of that operation.
    logic [LAT-1:0]     busy_reg;
    logic [IW-1:0]      inflight_reg;
    logic               retire;

    // Reset and hold both mask every request so nothing transfers in those cycles
    assign eligible = req_valid & ~hazard & {NTHREAD{~hold & ~rst}};

    // Round-robin search starting at ptr; NTHREAD is a power of two so the
    // TW-bit addition wraps naturally
    always_comb begin
        grant_any = 1'b0;
        grant_idx = ptr_reg;
        cand      = ptr_reg;
        for (int i = 0; i < NTHREAD; i++) begin
            cand = ptr_reg + TW'(i);
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign req_ready  = grant_any ? (NTHREAD'(1) << grant_idx) : '0;

    assign sel_raddr0 = req_raddr0[grant_idx*AW +: AW];
    assign sel_raddr1 = req_raddr1[grant_idx*AW +: AW];
    assign sel_waddr  = req_waddr[grant_idx*AW +: AW];
    assign sel_we     = req_we[grant_idx];

    // Pointer moves past the granted thread; it stays put when nothing is granted
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (grant_any) begin
            ptr_reg <= grant_idx + 1'b1;
        end
    end

    // Issue stage: strobe every cycle, fields only load on a grant
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_reg  <= 1'b0;
            iss_thread_reg <= '0;
            iss_raddr0_reg <= '0;
            iss_raddr1_reg <= '0;
            iss_waddr_reg  <= '0;
            iss_we_reg     <= 1'b0;
        end else begin
            iss_valid_reg <= grant_any;
            if (grant_any) begin
                iss_thread_reg <= grant_idx;
                iss_raddr0_reg <= sel_raddr0;
                iss_raddr1_reg <= sel_raddr1;
                iss_waddr_reg  <= sel_waddr;
                iss_we_reg     <= sel_we;
            end
        end
    end

    // Occupancy shift line; reset drops every entry so no retirement follows
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg[0] <= grant_any;
            for (int i = 1; i < LAT; i++) begin
                busy_reg[i] <= busy_reg[i-1];
            end
        end
    end

    assign retire = busy_reg[LAT-1];

    // In-flight counter; a grant and a retirement in the same cycle cancel
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_reg <= '0;
        end else if (grant_any && !retire) begin
            inflight_reg <= inflight_reg + 1'b1;
        end else if (!grant_any && retire) begin
            inflight_reg <= inflight_reg - 1'b1;
        end
    end

`ifdef THREAD_ISSUE_HAZARD_CHECK_EN
    // Write-back window: stage i holds a writing operation granted i+1 cycles ago
    logic [LAT-1:0] sb_wr_reg;
    logic [TW-1:0]  sb_thread_reg [LAT];
    logic [AW-1:0]  sb_waddr_reg  [LAT];

    // Entry valid bits, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_wr_reg <= '0;
        end else begin
            sb_wr_reg[0] <= grant_any & sel_we;
            for (int i = 1; i < LAT; i++) begin
                sb_wr_reg[i] <= sb_wr_reg[i-1];
            end
        end
    end

    // Entry payload; only meaningful where the matching valid bit is set
    always_ff @(posedge clk) begin
        sb_thread_reg[0] <= grant_idx;
        sb_waddr_reg[0]  <= sel_waddr;
        for (int i = 1; i < LAT; i++) begin
            sb_thread_reg[i] <= sb_thread_reg[i-1];
            sb_waddr_reg[i]  <= sb_waddr_reg[i-1];
        end
    end

    // A thread is blocked only by its own pending writes touching any of its addresses
    for (genvar gi = 0; gi < NTHREAD; gi++) begin : g_hazard
        logic [LAT-1:0] hit;
        for (genvar gj = 0; gj < LAT; gj++) begin : g_stage
            assign hit[gj] = sb_wr_reg[gj]
                          && (sb_thread_reg[gj] == TW'(gi))
                          && ((sb_waddr_reg[gj] == req_raddr0[gi*AW +: AW])
                           || (sb_waddr_reg[gj] == req_raddr1[gi*AW +: AW])
                           || (sb_waddr_reg[gj] == req_waddr[gi*AW +: AW]));
        end
        assign hazard[gi] = |hit;
    end
`else
    assign hazard = '0;
`endif

    assign iss_valid  = iss_valid_reg;
    assign iss_thread = iss_thread_reg;
    assign iss_raddr0 = iss_raddr0_reg;
    assign iss_raddr1 = iss_raddr1_reg;
    assign iss_waddr  = iss_waddr_reg;
    assign iss_we     = iss_we_reg;
    assign inflight   = inflight_reg;
    assign drained    = (inflight_reg == '0);

endmodule

// File: tb/tb_thread_issue_arbiter.sv
// Testbench for thread_issue_arbiter (NTHREAD=4, LAT=8, AW=9).
// A queue-based reference model predicts every output each cycle; directed
// scenarios add hand-computed literal expectations.
module tb_thread_issue_arbiter;
    localparam int NT  = 4;
    localparam int LAT = 8;
    localparam int AW  = 9;
    localparam int TW  = 2;
    localparam int IW  = 4;

    logic              clk;
    logic              rst;
    logic              hold;
    logic [NT-1:0]     req_valid;
    logic [NT-1:0]     req_we;
    logic [NT-1:0]     req_ready;
    logic [NT*AW-1:0]  req_raddr0;
    logic [NT*AW-1:0]  req_raddr1;
    logic [NT*AW-1:0]  req_waddr;
    logic              iss_valid;
    logic              iss_we;
    logic [TW-1:0]     iss_thread;
    logic [AW-1:0]     iss_raddr0;
    logic [AW-1:0]     iss_raddr1;
    logic [AW-1:0]     iss_waddr;
    logic [IW-1:0]     inflight;
    logic              drained;

    thread_issue_arbiter #(.NTHREAD(NT), .LAT(LAT), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_raddr0 (req_raddr0),
        .req_raddr1 (req_raddr1),
        .req_waddr  (req_waddr),
        .req_we     (req_we),
        .hold       (hold),
        .req_ready  (req_ready),
        .iss_valid  (iss_valid),
        .iss_thread (iss_thread),
        .iss_raddr0 (iss_raddr0),
        .iss_raddr1 (iss_raddr1),
        .iss_waddr  (iss_waddr),
        .iss_we     (iss_we),
        .inflight   (inflight),
        .drained    (drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk   = 0;
    int n_err   = 0;
    int cyc     = 0;
    int abs_cyc = 0;

    // Reference model: list of granted operations with their grant cycle
    typedef struct {
        int t;
        int thr;
        int wa;
        bit we;
    } op_t;
    op_t ops[$];
    int  mptr  = 0;
    bit  e_v   = 0;
    bit  e_we  = 0;
    int  e_thr = 0;
    int  e_ra0 = 0;
    int  e_ra1 = 0;
    int  e_wa  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", nm, abs_cyc, act, exp);
        end
    endtask

    function automatic bit hazard_of(input int k);
        bit h = 1'b0;
`ifdef THREAD_ISSUE_HAZARD_CHECK_EN
        foreach (ops[i]) begin
            if (ops[i].we && ops[i].thr == k &&
                (ops[i].wa == int'(req_raddr0[k*AW +: AW]) ||
                 ops[i].wa == int'(req_raddr1[k*AW +: AW]) ||
                 ops[i].wa == int'(req_waddr[k*AW +: AW])))
                h = 1'b1;
        end
`else
        h = (k < 0);
`endif
        return h;
    endfunction

    // Compare all outputs with the model, then advance the model across the edge
    task automatic model_step();
        int g = -1;
        int k;
        logic [NT-1:0] er = '0;
        while (ops.size() > 0 && ops[0].t + LAT < abs_cyc) void'(ops.pop_front());
        if (!rst && !hold) begin
            for (int i = 0; i < NT; i++) begin
                k = (mptr + i) % NT;
                if (g < 0 && req_valid[k] && !hazard_of(k)) g = k;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        chk("ready", 32'(req_ready), 32'(er));
        chk("iss_valid", 32'(iss_valid), 32'(e_v));
        chk("iss_thread", 32'(iss_thread), e_thr);
        chk("iss_raddr0", 32'(iss_raddr0), e_ra0);
        chk("iss_raddr1", 32'(iss_raddr1), e_ra1);
        chk("iss_waddr", 32'(iss_waddr), e_wa);
        chk("iss_we", 32'(iss_we), 32'(e_we));
        chk("inflight", 32'(inflight), ops.size());
        chk("drained", 32'(drained), 32'(ops.size() == 0));
        if (rst) begin
            ops.delete();
            mptr = 0; e_v = 0; e_we = 0; e_thr = 0; e_ra0 = 0; e_ra1 = 0; e_wa = 0;
        end else if (g >= 0) begin
            ops.push_back('{t: abs_cyc, thr: g, wa: int'(req_waddr[g*AW +: AW]), we: req_we[g]});
            mptr  = (g + 1) % NT;
            e_v   = 1;
            e_thr = g;
            e_ra0 = int'(req_raddr0[g*AW +: AW]);
            e_ra1 = int'(req_raddr1[g*AW +: AW]);
            e_wa  = int'(req_waddr[g*AW +: AW]);
            e_we  = req_we[g];
        end else begin
            e_v = 0;
        end
        abs_cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_thr(input int k, input bit v, input int ra0, input int ra1,
                           input int wa, input bit we);
        req_valid[k] = v;
        req_we[k]    = we;
        req_raddr0[k*AW +: AW] = AW'(ra0);
        req_raddr1[k*AW +: AW] = AW'(ra1);
        req_waddr[k*AW +: AW]  = AW'(wa);
    endtask

    task automatic reset_dut();
        req_valid = '0; req_we = '0; hold = 1'b0;
        req_raddr0 = '0; req_raddr1 = '0; req_waddr = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic rand_phase(input int n);
        logic [NT-1:0] granted;
        for (int c = 0; c < n; c++) begin
            for (int k = 0; k < NT; k++) begin
                if (!req_valid[k] && $urandom_range(0, 9) < 6)
                    set_thr(k, 1, $urandom_range(0, 7), $urandom_range(0, 7),
                            $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            end
            rst  = ($urandom_range(0, 99) == 0);
            hold = ($urandom_range(0, 9) == 0);
            #1;
            granted = req_valid & req_ready;
            tick();
            for (int k = 0; k < NT; k++) begin
                if (granted[k]) begin
                    if ($urandom_range(0, 1) == 0)
                        set_thr(k, 0, 0, 0, 0, 0);
                    else
                        set_thr(k, 1, $urandom_range(0, 7), $urandom_range(0, 7),
                                $urandom_range(0, 7), 1'($urandom_range(0, 1)));
                end
            end
        end
        rst  = 1'b0;
        hold = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0;
        req_valid = '0; req_we = '0;
        req_raddr0 = '0; req_raddr1 = '0; req_waddr = '0;
        @(posedge clk);
        #1;

        // Reset state
        reset_dut();
        #1;
        chk("rst_inflight", 32'(inflight), 0);
        chk("rst_drained", 32'(drained), 1);
        chk("rst_iss_valid", 32'(iss_valid), 0);

        // All threads busy: strict rotation and saturation of inflight
        reset_dut();
        for (int k = 0; k < NT; k++) set_thr(k, 1, 'h40 + k, 'h50 + k, 'h60 + k, 0);
        for (int c = 0; c < 12; c++) begin
            #1;
            chk("rr_order", 32'(req_ready), 1 << (cyc % 4));
            chk("rr_inflight", 32'(inflight), (cyc < 8) ? cyc : 8);
            if (cyc >= 1) begin
                chk("rr_iss_valid", 32'(iss_valid), 1);
                chk("rr_iss_thread", 32'(iss_thread), (cyc - 1) % 4);
            end
            tick();
        end

        // Own pending write blocks thread 1
        reset_dut();
        for (int c = 0; c < 20; c++) begin
            if (cyc == 10) set_thr(1, 1, 'h001, 'h002, 'h010, 1);
            else if (cyc == 11) set_thr(1, 1, 'h010, 'h011, 'h012, 0);
            #1;
            if (cyc == 10) chk("haz_first", 32'(req_ready), 32'b0010);
`ifdef THREAD_ISSUE_HAZARD_CHECK_EN
            if (cyc >= 11 && cyc <= 18) chk("haz_blocked", 32'(req_ready[1]), 0);
            if (cyc == 19) chk("haz_release", 32'(req_ready), 32'b0010);
`else
            if (cyc == 11) chk("nohaz_grant", 32'(req_ready), 32'b0010);
`endif
            tick();
        end

        // Another thread reading the same address is not blocked
        reset_dut();
        for (int c = 0; c < 13; c++) begin
            if (cyc == 10) set_thr(1, 1, 'h001, 'h002, 'h010, 1);
            else if (cyc == 11) begin
                set_thr(1, 1, 'h010, 'h011, 'h012, 0);
                set_thr(2, 1, 'h010, 'h020, 'h021, 0);
            end else if (cyc == 12) set_thr(2, 0, 0, 0, 0, 0);
            #1;
            if (cyc == 11) chk("haz_other_thread", 32'(req_ready), 32'b0100);
`ifdef THREAD_ISSUE_HAZARD_CHECK_EN
            if (cyc == 12) chk("haz_still_blocked", 32'(req_ready), 0);
`else
            if (cyc == 12) chk("nohaz_next", 32'(req_ready), 32'b0010);
`endif
            tick();
        end

        // Hold freezes grants and pointer
        reset_dut();
        for (int k = 0; k < NT; k++) set_thr(k, 1, 'h40 + k, 'h50 + k, 'h60 + k, 0);
        for (int c = 0; c < 11; c++) begin
            hold = (cyc >= 5 && cyc <= 9);
            #1;
            if (cyc < 5) chk("hold_pre", 32'(req_ready), 1 << (cyc % 4));
            if (hold) chk("hold_ready", 32'(req_ready), 0);
            if (cyc >= 6) chk("hold_iss_valid", 32'(iss_valid), 0);
            if (cyc == 10) chk("hold_resume", 32'(req_ready), 32'b0010);
            tick();
        end
        hold = 1'b0;

        // Reset mid-operation discards in-flight work and hazards
        reset_dut();
        set_thr(0, 1, 'h001, 'h002, 'h005, 1);
        for (int c = 0; c < 7; c++) begin
            if (cyc == 1) begin
                set_thr(0, 1, 'h005, 'h100, 'h101, 0);
                for (int k = 1; k < NT; k++) set_thr(k, 1, 'h110 + k, 'h120 + k, 'h130 + k, 0);
            end
            rst = (cyc == 5);
            #1;
            if (cyc == 5) begin
                chk("mid_rst_inflight", 32'(inflight), 5);
                chk("mid_rst_ready", 32'(req_ready), 0);
            end
            if (cyc == 6) begin
                chk("post_rst_inflight", 32'(inflight), 0);
                chk("post_rst_drained", 32'(drained), 1);
                chk("post_rst_iss_valid", 32'(iss_valid), 0);
                chk("post_rst_grant", 32'(req_ready), 32'b0001);
            end
            tick();
        end
        rst = 1'b0;

        // Single grant: inflight window timing and drained edge
        reset_dut();
        for (int c = 0; c < 14; c++) begin
            set_thr(0, cyc == 3, 'h1, 'h2, 'h3, 0);
            #1;
            if (cyc == 3) chk("single_grant", 32'(req_ready), 32'b0001);
            if (cyc >= 4 && cyc <= 11) chk("single_inflight", 32'(inflight), 1);
            if (cyc == 11) chk("single_not_drained", 32'(drained), 0);
            if (cyc == 12) begin
                chk("single_retired", 32'(inflight), 0);
                chk("single_drained", 32'(drained), 1);
            end
            tick();
        end

        // Randomized traffic with hold and occasional reset
        reset_dut();
        rand_phase(3000);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
